// File: rtl/regs_wb_arbiter_if.sv
// regs_wb_arbiter_if
//   Bundles the writeback request channel, the clear-sweep request and the
//   register-file write port that the writeback arbiter sits between.
//   Signals:
//     req_valid  [NUM_REQ]     per-requester write request
//     req_addr   [NUM_REQ*AW]  packed destination register, requester i at [i*AW +: AW]
//     req_data   [NUM_REQ*DW]  packed write data, requester i at [i*DW +: DW]
//     req_ready  [NUM_REQ]     one-hot grant back to the requesters
//     clear_req                single-cycle pulse requesting an x1..x31 clear sweep
//     w_regs_addr/data/en      registered register-file write port
//     init_done                high while the arbiter is in normal operation
//   Modports:
//     master  the writeback sources / register-file side (drives requests)
//     slave   the arbiter itself
interface regs_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 5,
  parameter int DW      = 32
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  clear_req;
  logic [AW-1:0]         w_regs_addr;
  logic [DW-1:0]         w_regs_data;
  logic                  w_regs_en;
  logic                  init_done;

  modport master (
    output req_valid, req_addr, req_data, clear_req,
    input  req_ready, w_regs_addr, w_regs_data, w_regs_en, init_done
  );

  modport slave (
    input  req_valid, req_addr, req_data, clear_req,
    output req_ready, w_regs_addr, w_regs_data, w_regs_en, init_done
  );
endinterface

// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter
//   Shares the single register-file write port among NUM_REQ writeback
//   sources. After reset (and on clear_req) it sweeps x1..x(2^AW-1) with
//   zeros, since the register file only initialises x0; afterwards it
//   round-robin arbitrates valid/ready requests into one registered write
//   per cycle.
//   Ports:
//     clk  clock
//     rst  asynchronous active-high reset
//     bus  regs_wb_arbiter_if.slave (requests, grants, write port, init_done)
module regs_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 5,
  parameter int DW      = 32
) (
  input logic            clk,
  input logic            rst,
  regs_wb_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   sweep_reg, sweep_next;
  logic [PW-1:0]   rr_reg, rr_next;
  logic            en_reg, en_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [DW-1:0]   data_reg, data_next;
  logic            done_reg, done_next;

  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      grant_idx;
  logic               grant_any;
  int                 cand;

  // Unpacked views of the packed request buses
  logic [AW-1:0] addr_arr [NUM_REQ];
  logic [DW-1:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = bus.req_addr[gi*AW +: AW];
    assign data_arr[gi] = bus.req_data[gi*DW +: DW];
  end

  // Round-robin search starting just above the last granted index. The
  // clear_req cycle grants nobody so the sweep cannot race a write.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (state_reg == ST_RUN && !bus.clear_req) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = int'(rr_reg) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        if (!grant_any && bus.req_valid[PW'(cand)]) begin
          grant_any = 1'b1;
          grant_idx = PW'(cand);
        end
      end
    end
    grant = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  assign bus.req_ready = grant;

  // Next-state and output-register logic
  always_comb begin
    state_next = state_reg;
    sweep_next = sweep_reg;
    rr_next    = rr_reg;
    en_next    = 1'b0;
    addr_next  = addr_reg;
    data_next  = data_reg;
    case (state_reg)
      ST_INIT: begin
        en_next   = 1'b1;
        addr_next = sweep_reg;
        data_next = '0;
        if (sweep_reg == {AW{1'b1}}) begin
          state_next = ST_RUN;
          sweep_next = AW'(1);
        end else begin
          sweep_next = sweep_reg + AW'(1);
        end
      end
      ST_RUN: begin
        if (bus.clear_req) begin
          state_next = ST_INIT;
        end else if (grant_any) begin
          // x0 writes are consumed but never reach the register file
          en_next   = (addr_arr[grant_idx] != '0);
          addr_next = addr_arr[grant_idx];
          data_next = data_arr[grant_idx];
          rr_next   = grant_idx;
        end
      end
      default: state_next = ST_INIT;
    endcase
    done_next = (state_next == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_INIT;
      sweep_reg <= AW'(1);
      rr_reg    <= PW'(NUM_REQ - 1);
      en_reg    <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sweep_reg <= sweep_next;
      rr_reg    <= rr_next;
      en_reg    <= en_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
    end
  end

  assign bus.w_regs_en   = en_reg;
  assign bus.w_regs_addr = addr_reg;
  assign bus.w_regs_data = data_reg;
  assign bus.init_done   = done_reg;
endmodule

// File: tb/tb_regs_wb_arbiter.sv
// tb_regs_wb_arbiter
//   Directed bench for regs_wb_arbiter: reset sweep, single request,
//   round-robin order, x0 write, clear_req in RUN, reset mid-sweep.
module tb_regs_wb_arbiter;
  localparam int NUM_REQ = 3;
  localparam int AW      = 5;
  localparam int DW      = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  regs_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) bus ();

  regs_wb_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  // Runs the 31-cycle zero sweep, checking every write; expects the
  // arbiter to have entered INIT before the first step.
  task automatic sweep(input logic [NUM_REQ-1:0] ready_after);
    for (int i = 1; i <= 31; i++) begin
      step();
      chk($sformatf("sweep_en[%0d]", i), 32'(bus.w_regs_en), 32'd1);
      chk($sformatf("sweep_addr[%0d]", i), 32'(bus.w_regs_addr), 32'(i));
      chk($sformatf("sweep_data[%0d]", i), bus.w_regs_data, 32'd0);
      chk($sformatf("sweep_done[%0d]", i), 32'(bus.init_done), (i == 31) ? 32'd1 : 32'd0);
      chk($sformatf("sweep_ready[%0d]", i), 32'(bus.req_ready),
          (i == 31) ? 32'(ready_after) : 32'd0);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.clear_req = 1'b0;

    // Reset state
    step();
    chk("rst_en", 32'(bus.w_regs_en), 32'd0);
    chk("rst_addr", 32'(bus.w_regs_addr), 32'd0);
    chk("rst_data", bus.w_regs_data, 32'd0);
    chk("rst_done", 32'(bus.init_done), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    $display("phase: reset release sweep");
    sweep(3'b000);
    step();
    chk("idle_en", 32'(bus.w_regs_en), 32'd0);
    chk("idle_done", 32'(bus.init_done), 32'd1);

    // Single request from requester 1
    $display("phase: single request");
    set_req(1, 5'd5, 32'hDEADBEEF);
    bus.req_valid = 3'b010;
    #1 chk("single_ready", 32'(bus.req_ready), 32'b010);
    step();
    bus.req_valid = '0;
    chk("single_en", 32'(bus.w_regs_en), 32'd1);
    chk("single_addr", 32'(bus.w_regs_addr), 32'd5);
    chk("single_data", bus.w_regs_data, 32'hDEADBEEF);
    step();
    chk("single_en_drop", 32'(bus.w_regs_en), 32'd0);
    chk("single_addr_hold", 32'(bus.w_regs_addr), 32'd5);

    // Round-robin with all requesters valid after a fresh reset
    $display("phase: round robin");
    rst = 1'b1;
    #1 chk("rst_run_en", 32'(bus.w_regs_en), 32'd0);
    chk("rst_run_addr", 32'(bus.w_regs_addr), 32'd0);
    chk("rst_run_data", bus.w_regs_data, 32'd0);
    chk("rst_run_done", 32'(bus.init_done), 32'd0);
    step();
    rst = 1'b0;
    set_req(0, 5'd10, 32'hA0);
    set_req(1, 5'd11, 32'hB1);
    set_req(2, 5'd12, 32'hC2);
    bus.req_valid = 3'b111;
    #1 chk("rr_init_ready", 32'(bus.req_ready), 32'd0);
    sweep(3'b001);
    for (int c = 0; c < 6; c++) begin
      int g;
      g = c % 3;
      chk($sformatf("rr_ready[%0d]", c), 32'(bus.req_ready), 32'd1 << g);
      step();
      chk($sformatf("rr_en[%0d]", c), 32'(bus.w_regs_en), 32'd1);
      chk($sformatf("rr_addr[%0d]", c), 32'(bus.w_regs_addr), 32'(10 + g));
      chk($sformatf("rr_data[%0d]", c), bus.w_regs_data, 32'hA0 + 32'(g) * 32'h11);
      $display("rr cycle %0d: grant %0d addr %0d", c, g, bus.w_regs_addr);
    end

    // x0 write from requester 2 after requester 1 was last granted
    $display("phase: x0 write");
    bus.req_valid = 3'b010;
    #1 chk("x0_pre_ready", 32'(bus.req_ready), 32'b010);
    step();
    chk("x0_pre_addr", 32'(bus.w_regs_addr), 32'd11);
    set_req(2, 5'd0, 32'h1234);
    bus.req_valid = 3'b100;
    #1 chk("x0_ready", 32'(bus.req_ready), 32'b100);
    step();
    chk("x0_en", 32'(bus.w_regs_en), 32'd0);
    chk("x0_addr", 32'(bus.w_regs_addr), 32'd0);
    chk("x0_data", bus.w_regs_data, 32'h1234);
    set_req(2, 5'd12, 32'hC2);
    bus.req_valid = 3'b111;
    #1 chk("x0_rr_ptr", 32'(bus.req_ready), 32'b001);

    // clear_req in RUN with a write in flight
    $display("phase: clear_req");
    bus.req_valid = 3'b010;
    #1 chk("clr_pre_ready", 32'(bus.req_ready), 32'b010);
    step();
    bus.req_valid = 3'b001;
    bus.clear_req = 1'b1;
    #1 chk("clr_ready", 32'(bus.req_ready), 32'd0);
    chk("clr_inflight_en", 32'(bus.w_regs_en), 32'd1);
    chk("clr_inflight_addr", 32'(bus.w_regs_addr), 32'd11);
    step();
    bus.clear_req = 1'b0;
    chk("clr_done", 32'(bus.init_done), 32'd0);
    chk("clr_en", 32'(bus.w_regs_en), 32'd0);
    chk("clr_init_ready", 32'(bus.req_ready), 32'd0);
    sweep(3'b001);
    step();
    bus.req_valid = '0;
    chk("clr_post_en", 32'(bus.w_regs_en), 32'd1);
    chk("clr_post_addr", 32'(bus.w_regs_addr), 32'd10);
    chk("clr_post_data", bus.w_regs_data, 32'hA0);

    // Reset asserted in the middle of a sweep
    $display("phase: reset mid-sweep");
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    for (int i = 1; i <= 12; i++) step();
    chk("mid_addr12", 32'(bus.w_regs_addr), 32'd12);
    rst = 1'b1;
    #1 chk("mid_rst_en", 32'(bus.w_regs_en), 32'd0);
    chk("mid_rst_addr", 32'(bus.w_regs_addr), 32'd0);
    chk("mid_rst_data", bus.w_regs_data, 32'd0);
    chk("mid_rst_done", 32'(bus.init_done), 32'd0);
    step();
    rst = 1'b0;
    sweep(3'b000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Sequences and shares the single register-file write port (w_regs_addr/w_regs_data/w_regs_en) among NUM_REQ writeback sources: ALU, LSU and MDU by default.
- After reset it runs a clear sweep that writes 0 to x1..x31, because the register file only initialises x0; it also runs the sweep on demand.
- In normal operation it round-robin arbitrates valid/ready writeback requests into one registered write per cycle.
- It sits between the execute/memory writeback sources and the register file.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- AW, 5, register address width (32 registers).
- DW, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*AW  packed destination register; requester i is at [i*AW +: AW].
- req_data  in  NUM_REQ*DW  packed write data; requester i is at [i*DW +: DW].
- req_ready  out  NUM_REQ  one-hot grant; the request is accepted when valid&ready at a clock edge.
- clear_req  in  1  single-cycle pulse that requests a new x1..x31 clear sweep.
- w_regs_addr  out  AW  register-file write address (registered).
- w_regs_data  out  DW  register-file write data (registered).
- w_regs_en  out  1  register-file write enable (registered).
- init_done  out  1  high while in RUN state (registered).

Behaviour:
- Reset values: state=INIT, sweep_idx=1, rr_ptr=NUM_REQ-1, w_regs_en=0, w_regs_addr=0, w_regs_data=0, init_done=0, req_ready=0.
- Reset is asynchronous: asserting rst mid-sweep or mid-run aborts immediately. After rst deasserts, the sweep restarts from x1.
- States: INIT (clear sweep) and RUN (arbitration).
- INIT behaviour:
  - On every edge, the output register loads en=1, addr=sweep_idx, data=0, and sweep_idx increments.
  - On the edge that loads addr=31: state->RUN, init_done->1, sweep_idx->1.
  - The sweep produces 31 consecutive write cycles with no gaps.
  - req_ready is 0 for all requesters throughout INIT.
  - clear_req is ignored while in INIT.
- RUN arbitration:
  - req_ready is combinational from state, req_valid and rr_ptr. At most one bit is set.
  - The grant goes to the first valid requester searching from rr_ptr+1 upward, modulo NUM_REQ.
  - No valid requester means req_ready=0.
  - req_ready does not depend on req_addr or req_data.
- RUN acceptance:
  - On an accepting edge, the output register loads en=(addr!=0), addr, data, and rr_ptr becomes the granted index.
  - A write to x0 is consumed (ready asserted, rr_ptr advances) but produces w_regs_en=0. The addr/data outputs still load.
  - With no acceptance, w_regs_en=0 on the next cycle and addr/data hold their previous values.
- Latency: exactly 1 cycle from acceptance to w_regs_en.
- Throughput: 1 write per cycle. The output stage drains every cycle, so there is no backpressure beyond arbitration loss.
- clear_req in RUN:
  - At that edge, no request is accepted (req_ready is forced to 0 in the clear_req cycle).
  - state->INIT and init_done->0.
  - Any write already in the output register completes normally.
  - The sweep starts on the following edge.
- Requesters must hold valid, addr and data stable until accepted. The arbiter does not check this.
- Same-register conflicts between requesters are not detected. Ordering is strictly acceptance order.
- Round-robin fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once per NUM_REQ cycles.

Test Plan:
- Reset release, no requests:
  - w_regs_en is high for 31 cycles with addr 1,2,...,31 and data 0.
  - init_done rises on the edge loading addr 31.
  - w_regs_en is 0 afterwards and req_ready stays 0 until then.
- Single request in RUN:
  - req1 valid with addr=5, data=0xDEADBEEF.
  - Expected: req_ready=3'b010 in the same cycle; next cycle w_regs_en=1, addr=5, data=DEADBEEF.
- All three requesters valid continuously for 6 cycles after reset:
  - Grants are 0,1,2,0,1,2 (one-hot 001,010,100,...).
  - Output addrs follow the grant order, one write per cycle.
- x0 write:
  - req2 addr=0, data=0x1234.
  - Expected: req_ready[2]=1 and rr_ptr advances to 2; next cycle w_regs_en=0.
- clear_req in RUN with req0 valid in the same cycle:
  - Expected: req_ready=0 that cycle and init_done falls.
  - Then a 31-cycle sweep (addr 1..31, data 0) runs, after which req0 is granted.
- rst asserted mid-sweep (at addr 12):
  - Outputs go to 0 immediately.
  - After release, the sweep restarts at addr 1 and init_done stays 0 until addr 31.
